// File: rtl/master_out_port_pkg.sv
// Shared widths, state encoding and field bit limits for the serial master/slave port pair.
package master_out_port_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int BURST_W = 13;

  localparam int ADDR_BITS_LAST  = ADDR_W - 1;
  localparam int BURST_BITS_LAST = BURST_W - 1;
  localparam int DATA_BITS_LAST  = DATA_W - 1;

  // Wide enough for the longest write: 8 bits * 8191 beats.
  localparam int CNT_W  = 16;
  localparam int DBIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_HS = 3'd2,
    SHIFT   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/master_out_port_if.sv
// Request, write-byte stream, bus handshake and serial lines between request logic and the bus.
interface master_out_port_if;
  import master_out_port_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [ADDR_W-1:0]  req_addr;
  logic [BURST_W-1:0] req_burst;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_valid;
  logic               wr_ready;
  logic               master_valid;
  logic               slave_ready;
  logic               read_en;
  logic               write_en;
  logic               tx_address;
  logic               tx_data;
  logic               tx_burst;
  logic               tx_done;
  logic               tx_err;

  modport master (
    input  req_valid, req_write, req_addr, req_burst, wr_data, wr_valid, slave_ready,
    output req_ready, wr_ready, master_valid, read_en, write_en,
    output tx_address, tx_data, tx_burst, tx_done, tx_err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_burst, wr_data, wr_valid, slave_ready,
    input  req_ready, wr_ready, master_valid, read_en, write_en,
    input  tx_address, tx_data, tx_burst, tx_done, tx_err
  );

endinterface

// File: rtl/master_out_port_piso_shift.sv
// LSB-first parallel-in serial-out shifter; bit 0 is on sout right after load, line reads 0 once empty.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  output logic         sout,
  output logic         empty
);

  localparam int RW = $clog2(W + 1);

  logic [W-1:0]  sr;
  logic [RW-1:0] left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      left <= '0;
    end else if (clear) begin
      sr   <= '0;
      left <= '0;
    end else if (load) begin
      sr   <= din;
      left <= RW'(W);
    end else if (shift && left != '0) begin
      sr   <= sr >> 1;
      left <= left - RW'(1);
    end
  end

  assign empty = (left == '0);
  assign sout  = sr[0] & ~empty;

endmodule

// File: rtl/master_out_port.sv
// Serial bus master: accepts a request, handshakes, then streams address/burst/write bytes LSB first.
// Handshake-to-tx_done is max(13, 8*beats) for writes, 13 for reads; a missing byte at a beat boundary ends data early.
module master_out_port
  import master_out_port_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  master_out_port_if.master  bus
);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BURST_W-1:0] beats_left;
  logic               is_write;
  logic               underrun;
  logic               req_ready_q, master_valid_q, read_en_q, write_en_q, tx_done_q, tx_err_q;

  logic addr_empty, burst_empty, data_empty;
  logic accept, shift_en, clear_all, load_pop;
  logic beat_end, pop_beat, starve, data_more, hdr_more, last_bit;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign shift_en  = ((state == WAIT_HS) && bus.slave_ready) || (state == SHIFT);
  assign clear_all = (state == DONE);
  assign load_pop  = (state == LOAD) && bus.wr_valid;

  // Data beats run back-to-back from the handshake, so the bit position within a byte is bit_cnt mod 8.
  assign beat_end  = (state == SHIFT) && is_write && !data_empty &&
                     (bit_cnt[DBIT_W-1:0] == DBIT_W'(DATA_BITS_LAST)) && (beats_left > BURST_W'(1));
  assign pop_beat  = beat_end && bus.wr_valid;
  assign starve    = beat_end && !bus.wr_valid;

  assign data_more = pop_beat || (!data_empty && (bit_cnt[DBIT_W-1:0] != DBIT_W'(DATA_BITS_LAST)));
  assign hdr_more  = (!addr_empty  && (bit_cnt < CNT_W'(ADDR_BITS_LAST))) ||
                     (!burst_empty && (bit_cnt < CNT_W'(BURST_BITS_LAST)));
  assign last_bit  = (state == SHIFT) && !data_more && !hdr_more;

  piso_shift #(.W(ADDR_W)) u_addr (
    .clk(clk), .reset(reset), .clear(clear_all), .load(accept), .din(bus.req_addr),
    .shift(shift_en), .sout(bus.tx_address), .empty(addr_empty)
  );

  piso_shift #(.W(BURST_W)) u_burst (
    .clk(clk), .reset(reset), .clear(clear_all), .load(accept), .din(bus.req_burst),
    .shift(shift_en), .sout(bus.tx_burst), .empty(burst_empty)
  );

  piso_shift #(.W(DATA_W)) u_data (
    .clk(clk), .reset(reset), .clear(clear_all), .load(load_pop || pop_beat), .din(bus.wr_data),
    .shift(shift_en), .sout(bus.tx_data), .empty(data_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      beats_left     <= '0;
      is_write       <= 1'b0;
      underrun       <= 1'b0;
      req_ready_q    <= 1'b1;
      master_valid_q <= 1'b0;
      read_en_q      <= 1'b0;
      write_en_q     <= 1'b0;
      tx_done_q      <= 1'b0;
      tx_err_q       <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          is_write    <= bus.req_write;
          beats_left  <= (bus.req_burst == '0) ? BURST_W'(1) : bus.req_burst;
          req_ready_q <= 1'b0;
          read_en_q   <= !bus.req_write;
          write_en_q  <= bus.req_write;
          if (bus.req_write) begin
            state <= LOAD;
          end else begin
            state          <= WAIT_HS;
            master_valid_q <= 1'b1;
          end
        end
        LOAD: if (bus.wr_valid) begin
          state          <= WAIT_HS;
          master_valid_q <= 1'b1;
        end
        WAIT_HS: if (bus.slave_ready) begin
          state          <= SHIFT;
          master_valid_q <= 1'b0;
          bit_cnt        <= CNT_W'(1);
        end
        SHIFT: begin
          if (starve)   underrun   <= 1'b1;
          if (pop_beat) beats_left <= beats_left - BURST_W'(1);
          if (last_bit) begin
            state      <= DONE;
            tx_done_q  <= 1'b1;
            tx_err_q   <= underrun || starve;
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          bit_cnt     <= '0;
          beats_left  <= '0;
          is_write    <= 1'b0;
          underrun    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.master_valid = master_valid_q;
  assign bus.read_en      = read_en_q;
  assign bus.write_en     = write_en_q;
  assign bus.tx_done      = tx_done_q;
  assign bus.tx_err       = tx_err_q;
  assign bus.wr_ready     = load_pop || pop_beat;

endmodule

// File: tb/tb_master_out_port.sv
// Directed transactions with a scoreboard of expected serial streams, checked by a handshake-triggered monitor.
module tb_master_out_port;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  master_out_port_if bus();

  master_out_port dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] burst;
    logic [31:0] data;
    logic [31:0] wrmask;
    int          len;
    bit          err;
    bit          wr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] wq[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Write-byte source: pops whatever the DUT strobed during the previous cycle.
  logic pend;
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    forever begin
      @(negedge clk);
      pend = bus.wr_ready;
      @(posedge clk);
      #1;
      if (pend && wq.size() > 0) void'(wq.pop_front());
      bus.wr_valid = (wq.size() > 0);
      bus.wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  // Monitor: captures every line from the handshake cycle until tx_done, then scores against the queue.
  bit          active = 0;
  int          k, rd_cnt, wr_cnt;
  logic [31:0] cap_addr, cap_burst, cap_data, cap_wr;
  exp_t        e;

  always @(negedge clk) begin
    if (reset) begin
      active = 0;
    end else begin
      if (bus.wr_ready) chk("wr_ready_needs_valid", {31'b0, bus.wr_valid}, 32'd1);
      if (!active && bus.tx_done) chk("unexpected_done", {31'b0, bus.tx_done}, 32'd0);
      if (!active && bus.master_valid && bus.slave_ready) begin
        active = 1; k = 0; rd_cnt = 0; wr_cnt = 0;
        cap_addr = '0; cap_burst = '0; cap_data = '0; cap_wr = '0;
      end
      if (active) begin
        if (bus.tx_done) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: tx_done seen, expected no transaction");
          end else begin
            e = sb.pop_front();
            chk("len", 32'(k), 32'(e.len));
            chk("tx_err", {31'b0, bus.tx_err}, {31'b0, e.err});
            chk("tx_address", cap_addr, e.addr);
            chk("tx_burst", cap_burst, e.burst);
            chk("tx_data", cap_data, e.data);
            chk("wr_ready_offsets", cap_wr, e.wrmask);
            chk("read_en_cycles", 32'(rd_cnt), 32'(e.wr ? 0 : e.len));
            chk("write_en_cycles", 32'(wr_cnt), 32'(e.wr ? e.len : 0));
            chk("en_in_done", {30'b0, bus.read_en, bus.write_en}, 32'd0);
          end
          active = 0;
        end else begin
          if (k == 1) chk("master_valid_drop", {31'b0, bus.master_valid}, 32'd0);
          if (k < 32) begin
            cap_addr[k]  = bus.tx_address;
            cap_burst[k] = bus.tx_burst;
            cap_data[k]  = bus.tx_data;
            cap_wr[k]    = bus.wr_ready;
          end
          rd_cnt += int'(bus.read_en);
          wr_cnt += int'(bus.write_en);
          k++;
        end
      end
    end
  end

  task automatic expect_txn(input bit wr, input logic [11:0] a, input logic [12:0] b,
                            input logic [31:0] d, input logic [31:0] m, input int len, input bit err);
    exp_t x;
    x.addr = {20'b0, a}; x.burst = {19'b0, b}; x.data = d; x.wrmask = m;
    x.len = len; x.err = err; x.wr = wr;
    sb.push_back(x);
  endtask

  task automatic issue(input bit wr, input logic [11:0] a, input logic [12:0] b);
    int n = 0;
    bus.req_write = wr; bus.req_addr = a; bus.req_burst = b; bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin tick(); n++; end
    tick();
    bus.req_valid = 1'b0;
    if (wr) chk("wr_ready_accept_plus1", {31'b0, bus.wr_ready}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.req_ready && sb.size() == 0) && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: still busy, %0d transactions pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic push_bytes(input logic [31:0] bytes, input int cnt);
    for (int i = 0; i < cnt; i++) wq.push_back(bytes[8*i +: 8]);
    tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_burst = '0;
    bus.slave_ready = 1'b1;
    #12;
    chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset_outputs", {23'b0, bus.master_valid, bus.read_en, bus.write_en, bus.tx_address,
                          bus.tx_data, bus.tx_burst, bus.tx_done, bus.tx_err, bus.wr_ready}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Read, addr 0xA5C, burst 0 -> single beat, 13 cycles.
    expect_txn(0, 12'hA5C, 13'd0, 32'h0, 32'h0, 13, 0);
    issue(0, 12'hA5C, 13'd0);
    wait_idle();

    // Single-beat write.
    push_bytes(32'h96, 1);
    expect_txn(1, 12'h001, 13'd1, 32'h96, 32'h0, 13, 0);
    issue(1, 12'h001, 13'd1);
    wait_idle();

    // Three-beat write, bytes always available.
    push_bytes(32'h332211, 3);
    expect_txn(1, 12'h7F0, 13'd3, 32'h332211, 32'h8080, 24, 0);
    issue(1, 12'h7F0, 13'd3);
    wait_idle();

    // Three-beat write, third byte missing at handshake+15.
    push_bytes(32'h5AC3, 2);
    expect_txn(1, 12'h456, 13'd3, 32'h5AC3, 32'h80, 16, 1);
    issue(1, 12'h456, 13'd3);
    wait_idle();

    // Two-beat write, second byte missing at handshake+7: length stays 13.
    push_bytes(32'hF0, 1);
    expect_txn(1, 12'h800, 13'd2, 32'hF0, 32'h0, 13, 1);
    issue(1, 12'h800, 13'd2);
    wait_idle();

    // slave_ready held low: request stays pending with bit 0 on the lines.
    bus.slave_ready = 1'b0;
    expect_txn(0, 12'h3F1, 13'd5, 32'h0, 32'h0, 13, 0);
    issue(0, 12'h3F1, 13'd5);
    for (int i = 0; i < 5; i++) begin
      chk("hold_master_valid", {31'b0, bus.master_valid}, 32'd1);
      chk("hold_lines", {29'b0, bus.tx_address, bus.tx_burst, bus.tx_data}, 32'b110);
      tick();
    end
    bus.slave_ready = 1'b1;
    wait_idle();

    // Reset six cycles after the handshake of a write aborts it.
    push_bytes(32'h030201, 3);
    issue(1, 12'h0AA, 13'd3);
    n = 0;
    while (!(bus.master_valid && bus.slave_ready) && n < 20) begin tick(); n++; end
    if (n >= 20) begin n_cmp++; n_bad++; $display("FAIL abort_handshake_timeout: no handshake"); end
    repeat (6) tick();
    reset = 1'b1;
    #1;
    chk("abort_outputs", {23'b0, bus.master_valid, bus.read_en, bus.write_en, bus.tx_address,
                          bus.tx_data, bus.tx_burst, bus.tx_done, bus.tx_err, bus.wr_ready}, 32'd0);
    wq.delete();
    tick(); tick();
    reset = 1'b0;
    chk("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
    tick();

    // Normal transaction after the abort.
    push_bytes(32'hCDAB, 2);
    expect_txn(1, 12'h123, 13'd2, 32'hCDAB, 32'h80, 16, 0);
    issue(1, 12'h123, 13'd2);
    wait_idle();

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/master_out_port.md
# master_out_port

Bus-side serial transmitter that sits between a master's request logic and the system bus and drives the serial slave input port. It accepts a parallel request (12-bit address, 13-bit burst length, write bytes through a ready/valid stream) and performs the valid/ready handshake. It then shifts address, burst length and write data LSB-first onto three serial lines, and signals completion or underrun.

## Interface
- ADDR_W, 12, address width; serialized on tx_address
- DATA_W, 8, data byte width; serialized on tx_data
- BURST_W, 13, burst-length width; serialized on tx_burst
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle and can accept a request
- req_write  in  1  1 = write, 0 = read; sampled on request accept
- req_addr  in  ADDR_W  start address; sampled on request accept
- req_burst  in  BURST_W  beat count; 0 and 1 both mean a single beat
- wr_data  in  DATA_W  write byte
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  one-cycle pop strobe for wr_data
- master_valid  out  1  bus handshake request
- slave_ready  in  1  bus handshake grant
- read_en  out  1  read transaction in progress
- write_en  out  1  write transaction in progress
- tx_address  out  1  serial address, LSB first
- tx_data  out  1  serial write data, LSB first
- tx_burst  out  1  serial burst length, LSB first
- tx_done  out  1  one-cycle pulse at transaction end
- tx_err  out  1  one-cycle pulse alongside tx_done when a write ended on underrun

## Operation
- States: IDLE, LOAD, WAIT_HS, SHIFT, DONE.
- IDLE: req_ready=1. On req_valid & req_ready:
  - latch addr, burst and write into shift registers;
  - set beats = (req_burst==0) ? 1 : req_burst;
  - go to LOAD.
- LOAD (writes only; reads go straight to WAIT_HS): wait for wr_valid, then pop the first byte (wr_ready=1 for that cycle) into the data shift register and go to WAIT_HS.
- WAIT_HS:
  - master_valid=1, read_en/write_en driven per request;
  - bit 0 of every active field is on its line;
  - on slave_ready=1 (handshake cycle) go to SHIFT with bit_cnt=1.
- SHIFT:
  - bit k of each field appears k cycles after the handshake cycle.
  - Address: 12 cycles. Burst: 13 cycles. Data: 8 cycles per beat, beats back-to-back, no gap.
  - A field's line is driven 0 once the field is exhausted.
- Beat boundary (write, more beats remaining):
  - in the cycle carrying bit 7 of the current beat, wr_ready=1 if wr_valid=1, and the byte loads for the next cycle;
  - if wr_valid=0 there, set an underrun flag; no further beats are sent.
- Transaction length: L = max(13, 8*beats) for writes, 13 for reads (L = 13 when there is an underrun before bit 13).
- DONE: single cycle; tx_done=1, tx_err = underrun flag; clear all registers; go to IDLE.
- Address is sent once per transaction; the slave increments it per beat.
- beats counter is BURST_W wide with no wrap; maximum is 8191 beats.

## Timing
- Reset value of every output is 0 except req_ready=1. Reset is async; mid-transaction it aborts immediately, with no tx_done.
- master_valid is high only in WAIT_HS and drops the cycle after the handshake.
- read_en/write_en go high on entering LOAD/WAIT_HS and stay high through the last SHIFT cycle; they are 0 in DONE.
- Latency:
  - request accept to WAIT_HS is 1 cycle (read) or at least 2 cycles (write, LOAD waits for wr_valid);
  - handshake to tx_done is L cycles.
- slave_ready is ignored outside WAIT_HS.
- req_valid is ignored outside IDLE.
- wr_ready never asserts without wr_valid.

## Structure
- Shared package: ADDR_W/DATA_W/BURST_W defaults, the state encoding, and the constant ADDR_BITS_LAST=11, BURST_BITS_LAST=12, DATA_BITS_LAST=7.
- The same package is used by the slave input port.
- One sub-module, piso_shift (parameterized width, load/shift/empty flag), instantiated three times; FSM and counters live in the top.

## Test plan
- Read, addr=0xA5C, burst=0:
  - master_valid until slave_ready;
  - tx_address shows 0,0,1,1,1,0,1,0,0,1,0,1 over 12 cycles;
  - tx_burst 0 for 13 cycles; read_en high 13 cycles;
  - tx_done 13 cycles after handshake; tx_data stays 0.
- Write single, addr=0x001, data=0x96: tx_data 0,1,1,0,1,0,0,1; tx_done 13 cycles after handshake; tx_err=0.
- Write burst=3, bytes 0x11,0x22,0x33 always valid:
  - wr_ready pulses at accept+1 and at handshake+7 and +15;
  - tx_burst serializes 3; tx_done at handshake+24.
- Burst=3 underrun (wr_valid low at handshake+15): second byte sent; tx_done at handshake+16 with tx_err=1.
- slave_ready held low 5 cycles: master_valid stays high, lines hold bit 0, no shifting.
- Assert reset at handshake+6 of a write: all outputs 0 the same cycle; req_ready=1 after release; a following request completes normally.
